// File: rtl/ahb_pkg.sv
// Shared AHB-lite definitions: transfer-type encodings and the address-phase
// record used by the arbiter's hold registers and issue mux.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Widest address the hold record carries; the arbiter's AW must not exceed it.
    localparam int AHB_AW_MAX = 32;

    typedef struct packed {
        logic [AHB_AW_MAX-1:0] haddr;
        logic                  hwrite;
        logic [2:0]            hsize;
    } ahb_addr_t;

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_ptr,
// wrapping around, so the last winner has lowest priority.
module ahb_rr_pick #(
    parameter int NM = 2,
    parameter int PW = $clog2(NM)
) (
    input  logic [NM-1:0] i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [NM-1:0] o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_valid
);

    // Scan ptr+1 .. ptr+NM (mod NM) and take the first requester.
    always_comb begin
        int   w_j;
        logic w_found;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 1; k <= NM; k++) begin
            w_j = (int'(i_ptr) + k) % NM;
            if (!w_found && i_req[w_j]) begin
                w_found      = 1'b1;
                o_valid      = 1'b1;
                o_idx        = PW'(w_j);
                o_grant[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB-lite input stage: NM masters share one slave port. An
// address phase that cannot be issued is parked in a one-deep hold register
// and the master is stalled in its data phase until the held transfer issues.
module ahb_master_arbiter
    import ahb_pkg::*;
#(
    parameter int NM = 2,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [1:0]    M_HTRANS    [NM],
    input  logic [AW-1:0] M_HADDR     [NM],
    input  logic          M_HWRITE    [NM],
    input  logic [2:0]    M_HSIZE     [NM],
    input  logic [DW-1:0] M_HWDATA    [NM],
    output logic          M_HREADY    [NM],
    output logic          M_HRESP     [NM],
    output logic [DW-1:0] M_HRDATA    [NM],
    output logic          S_HSEL,
    output logic [AW-1:0] S_HADDR,
    output logic [1:0]    S_HTRANS,
    output logic          S_HWRITE,
    output logic [2:0]    S_HSIZE,
    output logic [DW-1:0] S_HWDATA,
    output logic          S_HREADY,
    input  logic          S_HREADYOUT,
    input  logic [DW-1:0] S_HRDATA,
    input  logic          S_HRESP
);

    localparam int PW = (NM > 1) ? $clog2(NM) : 1;

    logic [NM-1:0] r_pend;
    ahb_addr_t     r_hold [NM];
    logic          r_d_vld;
    logic [PW-1:0] r_d_own;
    logic [PW-1:0] r_ptr;

    ahb_addr_t     w_live_addr [NM];
    ahb_addr_t     w_sel;
    logic [NM-1:0] w_live;
    logic [NM-1:0] w_req;
    logic [NM-1:0] w_grant;
    logic [NM-1:0] w_capture;
    logic [PW-1:0] w_idx;
    logic          w_any;
    logic          w_rdy;
    logic          w_issue;

    // Master-side ready/response depend only on registered state plus slave ready.
    always_comb begin
        for (int i = 0; i < NM; i++) begin
            M_HREADY[i] = 1'b1;
            M_HRESP[i]  = 1'b0;
            M_HRDATA[i] = S_HRDATA;
            if (r_pend[i]) begin
                M_HREADY[i] = 1'b0;
            end else if (r_d_vld && (r_d_own == PW'(i))) begin
                M_HREADY[i] = S_HREADYOUT;
            end
            if (r_d_vld && (r_d_own == PW'(i))) begin
                M_HRESP[i] = S_HRESP;
            end
        end
    end

    // Live requests, request vector and per-master address records.
    always_comb begin
        for (int i = 0; i < NM; i++) begin
            w_live[i] = ((M_HTRANS[i] == HTRANS_NONSEQ) || (M_HTRANS[i] == HTRANS_SEQ))
                        && M_HREADY[i];
            w_req[i]  = r_pend[i] | w_live[i];
            w_live_addr[i].haddr  = AHB_AW_MAX'(M_HADDR[i]);
            w_live_addr[i].hwrite = M_HWRITE[i];
            w_live_addr[i].hsize  = M_HSIZE[i];
        end
    end

    ahb_rr_pick #(
        .NM (NM),
        .PW (PW)
    ) u_pick (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_any)
    );

    assign w_rdy     = r_d_vld ? S_HREADYOUT : 1'b1;
    // Reset gating keeps the slave seeing IDLE while HRESETn is low.
    assign w_issue   = HRESETn & w_rdy & w_any;
    assign w_capture = w_live & ~(w_grant & {NM{w_issue}});

    // Issue mux: held record for a pending winner, live inputs otherwise.
    always_comb begin
        w_sel = '0;
        if (w_issue) begin
            w_sel = r_pend[w_idx] ? r_hold[w_idx] : w_live_addr[w_idx];
        end
    end

    assign S_HSEL   = w_issue;
    assign S_HTRANS = w_issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign S_HADDR  = w_sel.haddr[AW-1:0];
    assign S_HWRITE = w_sel.hwrite;
    assign S_HSIZE  = w_sel.hsize;
    assign S_HREADY = w_rdy;
    assign S_HWDATA = M_HWDATA[r_d_own];

    // Control state: pending flags, data-phase owner and round-robin pointer.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_pend  <= '0;
            r_d_vld <= 1'b0;
            r_d_own <= '0;
            r_ptr   <= PW'(NM - 1);
        end else begin
            if (w_rdy) begin
                r_d_vld <= w_any;
                if (w_any) begin
                    r_d_own <= w_idx;
                    r_ptr   <= w_idx;
                end
            end
            for (int i = 0; i < NM; i++) begin
                if (w_issue && w_grant[i]) begin
                    r_pend[i] <= 1'b0;
                end else if (w_capture[i]) begin
                    r_pend[i] <= 1'b1;
                end
            end
        end
    end

    // Hold registers are pure data; they are only read while r_pend is set.
    always_ff @(posedge HCLK) begin
        for (int i = 0; i < NM; i++) begin
            if (w_capture[i]) begin
                r_hold[i] <= w_live_addr[i];
            end
        end
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter with four masters and a scripted slave.
module tb_ahb_master_arbiter;

    localparam int NM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  m_htrans [NM];
    logic [31:0] m_haddr  [NM];
    logic        m_hwrite [NM];
    logic [2:0]  m_hsize  [NM];
    logic [31:0] m_hwdata [NM];
    logic        m_hready [NM];
    logic        m_hresp  [NM];
    logic [31:0] m_hrdata [NM];
    logic        s_hsel;
    logic [31:0] s_haddr;
    logic [1:0]  s_htrans;
    logic        s_hwrite;
    logic [2:0]  s_hsize;
    logic [31:0] s_hwdata;
    logic        s_hready;
    logic        s_hreadyout;
    logic [31:0] s_hrdata;
    logic        s_hresp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ahb_master_arbiter #(.NM(NM), .AW(32), .DW(32)) dut (
        .HCLK(clk), .HRESETn(rst_n),
        .M_HTRANS(m_htrans), .M_HADDR(m_haddr), .M_HWRITE(m_hwrite),
        .M_HSIZE(m_hsize), .M_HWDATA(m_hwdata),
        .M_HREADY(m_hready), .M_HRESP(m_hresp), .M_HRDATA(m_hrdata),
        .S_HSEL(s_hsel), .S_HADDR(s_haddr), .S_HTRANS(s_htrans),
        .S_HWRITE(s_hwrite), .S_HSIZE(s_hsize), .S_HWDATA(s_hwdata),
        .S_HREADY(s_hready), .S_HREADYOUT(s_hreadyout),
        .S_HRDATA(s_hrdata), .S_HRESP(s_hresp)
    );

    // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NM; i++) begin
            m_htrans[i] = 2'b00;
            m_haddr[i]  = 32'h0;
            m_hwrite[i] = 1'b0;
            m_hsize[i]  = 3'd0;
        end
    endtask

    task automatic drive(input int i, input logic [1:0] tr, input logic [31:0] a,
                         input logic w, input logic [2:0] sz);
        m_htrans[i] = tr;
        m_haddr[i]  = a;
        m_hwrite[i] = w;
        m_hsize[i]  = sz;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_all();
        for (int i = 0; i < NM; i++) m_hwdata[i] = 32'h0;
        s_hreadyout = 1'b1; s_hresp = 1'b0; s_hrdata = 32'h0;
        drive(0, 2'b10, 32'h40, 1'b0, 3'd2);
        #12;
        n_tests++; if (s_htrans !== 2'b00) begin n_fail++; $display("FAIL reset_htrans got %0h want 0", s_htrans); end
        n_tests++; if (s_hsel !== 1'b0) begin n_fail++; $display("FAIL reset_hsel got %0b want 0", s_hsel); end
        n_tests++; if (s_hready !== 1'b1) begin n_fail++; $display("FAIL reset_s_hready got %0b want 1", s_hready); end
        for (int i = 0; i < NM; i++) begin
            n_tests++; if (m_hready[i] !== 1'b1 || m_hresp[i] !== 1'b0) begin
                n_fail++; $display("FAIL reset_m%0d hready=%0b hresp=%0b want 1/0", i, m_hready[i], m_hresp[i]);
            end
        end
        idle_all();
        @(negedge clk); rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        drive(0, 2'b10, 32'h100, 1'b1, 3'd2); #1;
        n_tests++; if (s_haddr !== 32'h100 || s_htrans !== 2'b10 || s_hwrite !== 1'b1 || s_hsel !== 1'b1) begin
            n_fail++; $display("FAIL single_wr_addr got %h/%0h/%0b want 100/2/1", s_haddr, s_htrans, s_hwrite); end
        tick();
        drive(0, 2'b10, 32'h104, 1'b0, 3'd2); m_hwdata[0] = 32'hCAFE0001; #1;
        n_tests++; if (s_haddr !== 32'h104 || s_hwrite !== 1'b0 || m_hready[0] !== 1'b1) begin
            n_fail++; $display("FAIL single_rd_addr got %h/%0b/%0b want 104/0/1", s_haddr, s_hwrite, m_hready[0]); end
        n_tests++; if (s_hwdata !== 32'hCAFE0001) begin n_fail++; $display("FAIL single_wdata got %h want cafe0001", s_hwdata); end
        tick();
        idle_all(); s_hrdata = 32'h12345678; #1;
        n_tests++; if (m_hrdata[0] !== 32'h12345678 || m_hready[0] !== 1'b1 || s_htrans !== 2'b00) begin
            n_fail++; $display("FAIL single_rdata got %h/%0b/%0h want 12345678/1/0", m_hrdata[0], m_hready[0], s_htrans); end
        tick();
    endtask

    task automatic test_collision();
        pulse_reset();
        drive(0, 2'b10, 32'h300, 1'b1, 3'd2);
        drive(1, 2'b10, 32'h200, 1'b0, 3'd1); #1;
        n_tests++; if (s_haddr !== 32'h300 || m_hready[1] !== 1'b1) begin
            n_fail++; $display("FAIL coll_first got %h/%0b want 300/1", s_haddr, m_hready[1]); end
        tick();
        idle_all(); drive(1, 2'b00, 32'hDEAD, 1'b1, 3'd0); #1;
        n_tests++; if (m_hready[1] !== 1'b0 || m_hready[0] !== 1'b1) begin
            n_fail++; $display("FAIL coll_stall got m1=%0b m0=%0b want 0/1", m_hready[1], m_hready[0]); end
        n_tests++; if (s_haddr !== 32'h200 || s_htrans !== 2'b10 || s_hwrite !== 1'b0 || s_hsize !== 3'd1) begin
            n_fail++; $display("FAIL coll_held got %h/%0h/%0b/%0d want 200/2/0/1", s_haddr, s_htrans, s_hwrite, s_hsize); end
        tick();
        drive(0, 2'b10, 32'h400, 1'b0, 3'd2);
        drive(1, 2'b10, 32'h500, 1'b0, 3'd2); #1;
        n_tests++; if (s_haddr !== 32'h400 || m_hready[1] !== 1'b1) begin
            n_fail++; $display("FAIL coll_ptr got %h/%0b want 400/1", s_haddr, m_hready[1]); end
        tick();
        idle_all(); #1;
        n_tests++; if (s_haddr !== 32'h500 || m_hready[1] !== 1'b0) begin
            n_fail++; $display("FAIL coll_second got %h/%0b want 500/0", s_haddr, m_hready[1]); end
        tick(); #1;
        n_tests++; if (s_htrans !== 2'b00 || m_hready[1] !== 1'b1) begin
            n_fail++; $display("FAIL coll_drain got %0h/%0b want 0/1", s_htrans, m_hready[1]); end
        tick();
    endtask

    task automatic test_wait_states();
        drive(0, 2'b10, 32'h600, 1'b1, 3'd2); #1;
        n_tests++; if (s_haddr !== 32'h600) begin n_fail++; $display("FAIL wait_m0_addr got %h want 600", s_haddr); end
        tick();
        idle_all(); m_hwdata[0] = 32'hAAAA0000; s_hreadyout = 1'b0;
        drive(1, 2'b10, 32'h700, 1'b1, 3'd2); #1;
        n_tests++; if (s_hready !== 1'b0 || m_hready[0] !== 1'b0 || m_hready[1] !== 1'b1) begin
            n_fail++; $display("FAIL wait_ready got s=%0b m0=%0b m1=%0b want 0/0/1", s_hready, m_hready[0], m_hready[1]); end
        n_tests++; if (s_htrans !== 2'b00 || s_haddr !== 32'h0) begin
            n_fail++; $display("FAIL wait_no_issue got %0h/%h want 0/0", s_htrans, s_haddr); end
        for (int c = 0; c < 2; c++) begin
            tick();
            idle_all(); m_hwdata[1] = 32'hBBBB1111; #1;
            n_tests++; if (m_hready[1] !== 1'b0 || s_haddr !== 32'h0 || s_hwdata !== 32'hAAAA0000) begin
                n_fail++; $display("FAIL wait_hold%0d got m1=%0b addr=%h wd=%h want 0/0/aaaa0000", c, m_hready[1], s_haddr, s_hwdata); end
        end
        tick();
        s_hreadyout = 1'b1; #1;
        n_tests++; if (s_haddr !== 32'h700 || s_htrans !== 2'b10 || s_hwrite !== 1'b1 || m_hready[0] !== 1'b1) begin
            n_fail++; $display("FAIL wait_m1_issue got %h/%0h/%0b/%0b want 700/2/1/1", s_haddr, s_htrans, s_hwrite, m_hready[0]); end
        tick(); #1;
        n_tests++; if (s_hwdata !== 32'hBBBB1111 || m_hready[1] !== 1'b1) begin
            n_fail++; $display("FAIL wait_m1_wdata got %h/%0b want bbbb1111/1", s_hwdata, m_hready[1]); end
        tick();
    endtask

    task automatic test_error();
        drive(1, 2'b10, 32'h800, 1'b0, 3'd2);
        tick();
        idle_all(); s_hreadyout = 1'b0; s_hresp = 1'b1; #1;
        n_tests++; if (m_hresp[1] !== 1'b1 || m_hresp[0] !== 1'b0 || m_hready[1] !== 1'b0) begin
            n_fail++; $display("FAIL err_cycle1 got r1=%0b r0=%0b rdy1=%0b want 1/0/0", m_hresp[1], m_hresp[0], m_hready[1]); end
        tick();
        s_hreadyout = 1'b1; #1;
        n_tests++; if (m_hresp[1] !== 1'b1 || m_hresp[0] !== 1'b0 || m_hready[1] !== 1'b1) begin
            n_fail++; $display("FAIL err_cycle2 got r1=%0b r0=%0b rdy1=%0b want 1/0/1", m_hresp[1], m_hresp[0], m_hready[1]); end
        tick();
        s_hresp = 1'b0; #1;
        n_tests++; if (m_hresp[1] !== 1'b0) begin n_fail++; $display("FAIL err_clear got %0b want 0", m_hresp[1]); end
        tick();
    endtask

    task automatic test_fairness();
        logic [31:0] exp_addr;
        pulse_reset();
        for (int i = 0; i < NM; i++) drive(i, 2'b11, 32'h1000 * (i + 1), 1'b0, 3'd2);
        #1;
        for (int k = 0; k < 8; k++) begin
            exp_addr = 32'h1000 * ((k % NM) + 1);
            n_tests++; if (s_haddr !== exp_addr || s_htrans !== 2'b10) begin
                n_fail++; $display("FAIL fair_grant%0d got %h/%0h want %h/2", k, s_haddr, s_htrans, exp_addr); end
            tick(); #1;
        end
        idle_all();
        for (int k = 0; k < 5; k++) tick();
    endtask

    task automatic test_reset_mid();
        drive(0, 2'b10, 32'h900, 1'b0, 3'd2);
        drive(2, 2'b10, 32'hA00, 1'b0, 3'd2);
        tick();
        idle_all(); #1;
        n_tests++; if (m_hready[2] !== 1'b0) begin n_fail++; $display("FAIL rmid_pending got %0b want 0", m_hready[2]); end
        #1 rst_n = 1'b0; #1;
        n_tests++; if (m_hready[2] !== 1'b1 || m_hready[0] !== 1'b1 || s_htrans !== 2'b00 || s_hsel !== 1'b0 || s_hready !== 1'b1) begin
            n_fail++; $display("FAIL rmid_async got m2=%0b m0=%0b tr=%0h sel=%0b rdy=%0b want 1/1/0/0/1",
                               m_hready[2], m_hready[0], s_htrans, s_hsel, s_hready); end
        tick();
        @(negedge clk); rst_n = 1'b1;
        tick(); #1;
        n_tests++; if (s_htrans !== 2'b00 || m_hready[2] !== 1'b1) begin
            n_fail++; $display("FAIL rmid_cleared got %0h/%0b want 0/1", s_htrans, m_hready[2]); end
        drive(0, 2'b10, 32'hB00, 1'b0, 3'd2);
        drive(3, 2'b10, 32'hC00, 1'b0, 3'd2); #1;
        n_tests++; if (s_haddr !== 32'hB00) begin n_fail++; $display("FAIL rmid_prio got %h want b00", s_haddr); end
        tick();
        idle_all();
        tick(); tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_collision();
        test_wait_states();
        test_error();
        test_fairness();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
